// File: rtl/axil_decerr_slave_wr.sv
// ---------------------------------------------------------------------------
// axil_decerr_slave_wr
//
// Default write slave for the AXI-Lite interconnect write path. It sinks every
// write that matched no slave window: AW and W are accepted in either order,
// and each transaction gets a single write response carrying BRESP_CODE
// (DECERR by default). Only one transaction is outstanding at a time. Further
// AW/W beats are held off until the B handshake completes.
//
// For debug, the block counts completed error writes (saturating) and keeps
// the address of the most recent one. err_pulse strobes once per B handshake.
//
// Ports
//   aclk, aresetn      clock, synchronous active-low reset
//   s_axil_aw*         write address channel (awaddr captured, not decoded)
//   s_axil_w*          write data channel (data/strobes discarded)
//   s_axil_b*          write response channel (bresp is constant)
//   err_cnt            completed error writes, saturates at all-ones
//   err_addr           awaddr of the last completed error write
//   err_pulse          1-cycle strobe in the cycle after each B handshake
//   err_cnt_clr        synchronous clear of err_cnt (clear wins before count)
// ---------------------------------------------------------------------------
module axil_decerr_slave_wr #(
  parameter int          AXI_ADDR_WIDTH = 32,
  parameter int          AXI_DATA_WIDTH = 32,
  parameter int          CNT_WIDTH      = 16,
  parameter logic [1:0]  BRESP_CODE     = 2'b11
) (
  input  logic                        aclk,
  input  logic                        aresetn,

  input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic                        s_axil_awvalid,
  output logic                        s_axil_awready,

  input  logic [AXI_DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                        s_axil_wvalid,
  output logic                        s_axil_wready,

  output logic [1:0]                  s_axil_bresp,
  output logic                        s_axil_bvalid,
  input  logic                        s_axil_bready,

  output logic [CNT_WIDTH-1:0]        err_cnt,
  output logic [AXI_ADDR_WIDTH-1:0]   err_addr,
  output logic                        err_pulse,
  input  logic                        err_cnt_clr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GOT_AW = 2'd1,
    GOT_W  = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic                        init_q;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [CNT_WIDTH-1:0]        err_cnt_q, err_cnt_d;
  logic [AXI_ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
  logic                        err_pulse_q;

  logic aw_hs, w_hs, b_hs;

  // Write data is never stored. The fold keeps the inputs visibly consumed.
  logic unused_wbeat;
  assign unused_wbeat = ^{s_axil_wdata, s_axil_wstrb};

  // ---------------------------------------------------------------------
  // Channel outputs, decoded from registered state only.
  // The state register comes out of reset as IDLE, which would otherwise
  // raise the readies while aresetn is still low. init_q is cleared by reset
  // and set on the first edge with aresetn high. It gates the readies, so
  // they stay low throughout reset without a combinational path from aresetn.
  // ---------------------------------------------------------------------
  assign s_axil_awready = init_q & ((state_q == IDLE) | (state_q == GOT_W));
  assign s_axil_wready  = init_q & ((state_q == IDLE) | (state_q == GOT_AW));
  assign s_axil_bvalid  = (state_q == RESP);
  assign s_axil_bresp   = BRESP_CODE;

  assign err_cnt   = err_cnt_q;
  assign err_addr  = err_addr_q;
  assign err_pulse = err_pulse_q;

  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid  & s_axil_wready;
  assign b_hs  = s_axil_bvalid  & s_axil_bready;

  // ---------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    awaddr_d   = awaddr_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (aw_hs && w_hs) state_d = RESP;
        else if (aw_hs)    state_d = GOT_AW;
        else if (w_hs)     state_d = GOT_W;
      end
      GOT_AW: if (w_hs)  state_d = RESP;
      GOT_W:  if (aw_hs) state_d = RESP;
      RESP:   if (b_hs)  state_d = IDLE;
      default:           state_d = IDLE;
    endcase

    // awready is low in RESP, so the held address cannot be overwritten
    // while its response is still pending.
    if (aw_hs) awaddr_d = s_axil_awaddr;

    // The clear applies first, so a clear in the same cycle as a B handshake
    // leaves the count at 1.
    if (err_cnt_clr) err_cnt_d = '0;
    if (b_hs) begin
      err_addr_d = awaddr_q;
      if (err_cnt_d != {CNT_WIDTH{1'b1}}) err_cnt_d = err_cnt_d + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // State registers. Reset drops any partial or pending transaction.
  // ---------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      init_q      <= 1'b0;
      awaddr_q    <= '0;
      err_cnt_q   <= '0;
      err_addr_q  <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_q      <= 1'b1;
      awaddr_q    <= awaddr_d;
      err_cnt_q   <= err_cnt_d;
      err_addr_q  <= err_addr_d;
      err_pulse_q <= b_hs;
    end
  end

endmodule

// File: tb/tb_axil_decerr_slave_wr.sv
module tb_axil_decerr_slave_wr;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [AW-1:0] awaddr;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          wvalid, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic [CW-1:0] err_cnt;
  logic [AW-1:0] err_addr;
  logic          err_pulse, err_cnt_clr;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axil_decerr_slave_wr #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .CNT_WIDTH(CW), .BRESP_CODE(2'b11)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .err_cnt(err_cnt), .err_addr(err_addr), .err_pulse(err_pulse), .err_cnt_clr(err_cnt_clr)
  );

  typedef struct {
    logic          awv, wv, br, clr;
    logic [AW-1:0] addr;
    logic          e_awr, e_wr, e_bv, e_pulse;
    logic [CW-1:0] e_cnt;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic awv, logic wv, logic br, logic clr, logic [AW-1:0] addr,
                              logic awr, logic wr, logic bv, logic pls,
                              logic [CW-1:0] cnt, logic [AW-1:0] ea);
    vec_t v;
    v.awv = awv; v.wv = wv; v.br = br; v.clr = clr; v.addr = addr;
    v.e_awr = awr; v.e_wr = wr; v.e_bv = bv; v.e_pulse = pls;
    v.e_cnt = cnt; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge aclk);
  endtask

  task automatic chk_ch(input string nm, input logic awr, input logic wr, input logic bv);
    chk({nm, ".awready"}, 64'(awready), 64'(awr));
    chk({nm, ".wready"},  64'(wready),  64'(wr));
    chk({nm, ".bvalid"},  64'(bvalid),  64'(bv));
  endtask

  // Full write from IDLE: both beats together, then B accepted at once.
  // Optional clear is asserted in the B handshake cycle.
  task automatic do_write(input logic [AW-1:0] a, input logic clr_on_b);
    awaddr = a; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    cyc();
    chk("wr.bvalid", 64'(bvalid), 64'd1);
    awvalid = 1'b0; wvalid = 1'b0; err_cnt_clr = clr_on_b;
    cyc();
    err_cnt_clr = 1'b0;
  endtask

  initial begin
    int acc, bhs;

    // W-before-AW and AW-before-W sequences, one row per cycle.
    //            awv wv br clr addr           awr wr bv pls cnt  err_addr
    vecs[0]  = mk(0, 0, 1, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0);
    vecs[1]  = mk(1, 1, 1, 0, 32'hDEAD_0000, 1, 1, 0, 0, 0, 32'h0);
    vecs[2]  = mk(0, 0, 1, 0, 32'h0,         0, 0, 1, 0, 0, 32'h0);
    vecs[3]  = mk(0, 0, 1, 0, 32'h0,         1, 1, 0, 1, 1, 32'hDEAD_0000);
    vecs[4]  = mk(0, 1, 1, 0, 32'h0,         1, 1, 0, 0, 1, 32'hDEAD_0000);
    vecs[5]  = mk(0, 1, 1, 0, 32'h0,         1, 0, 0, 0, 1, 32'hDEAD_0000);
    vecs[6]  = mk(0, 1, 1, 0, 32'h0,         1, 0, 0, 0, 1, 32'hDEAD_0000);
    vecs[7]  = mk(0, 1, 1, 0, 32'h0,         1, 0, 0, 0, 1, 32'hDEAD_0000);
    vecs[8]  = mk(1, 0, 1, 0, 32'h1000_0004, 1, 0, 0, 0, 1, 32'hDEAD_0000);
    vecs[9]  = mk(0, 0, 1, 0, 32'h0,         0, 0, 1, 0, 1, 32'hDEAD_0000);
    vecs[10] = mk(0, 0, 1, 0, 32'h0,         1, 1, 0, 1, 2, 32'h1000_0004);
    vecs[11] = mk(1, 0, 1, 0, 32'h20,        1, 1, 0, 0, 2, 32'h1000_0004);
    vecs[12] = mk(1, 0, 1, 0, 32'h30,        0, 1, 0, 0, 2, 32'h1000_0004);
    vecs[13] = mk(0, 1, 1, 0, 32'h0,         0, 1, 0, 0, 2, 32'h1000_0004);
    vecs[14] = mk(0, 0, 1, 0, 32'h0,         0, 0, 1, 0, 2, 32'h1000_0004);
    vecs[15] = mk(0, 0, 1, 0, 32'h0,         1, 1, 0, 1, 3, 32'h20);

    aresetn = 1'b0; awaddr = '0; awvalid = 1'b0; wdata = 32'hA5A5_5A5A; wstrb = '1;
    wvalid = 1'b0; bready = 1'b1; err_cnt_clr = 1'b0;

    // Reset: three edges with aresetn low.
    repeat (3) cyc();
    chk_ch("rst", 0, 0, 0);
    chk("rst.err_cnt",   64'(err_cnt),   64'd0);
    chk("rst.err_addr",  64'(err_addr),  64'd0);
    chk("rst.err_pulse", 64'(err_pulse), 64'd0);
    chk("rst.bresp",     64'(bresp),     64'd3);

    aresetn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      awvalid = vecs[i].awv; wvalid = vecs[i].wv; bready = vecs[i].br;
      err_cnt_clr = vecs[i].clr; awaddr = vecs[i].addr;
      chk($sformatf("vec%0d.awready", i), 64'(awready),   64'(vecs[i].e_awr));
      chk($sformatf("vec%0d.wready", i),  64'(wready),    64'(vecs[i].e_wr));
      chk($sformatf("vec%0d.bvalid", i),  64'(bvalid),    64'(vecs[i].e_bv));
      chk($sformatf("vec%0d.pulse", i),   64'(err_pulse), 64'(vecs[i].e_pulse));
      chk($sformatf("vec%0d.cnt", i),     64'(err_cnt),   64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d.addr", i),    64'(err_addr),  64'(vecs[i].e_addr));
      chk($sformatf("vec%0d.bresp", i),   64'(bresp),     64'd3);
      cyc();
    end
    awvalid = 1'b0; wvalid = 1'b0;

    // B back-pressure: response held 10 cycles, new beats held off.
    awaddr = 32'h44; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    cyc();
    awaddr = 32'h48;
    for (int i = 0; i < 10; i++) begin
      chk_ch($sformatf("bp%0d", i), 0, 0, 1);
      chk($sformatf("bp%0d.bresp", i), 64'(bresp),     64'd3);
      chk($sformatf("bp%0d.pulse", i), 64'(err_pulse), 64'd0);
      cyc();
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    cyc();
    chk_ch("bp_done", 1, 1, 0);
    chk("bp_done.pulse", 64'(err_pulse), 64'd1);
    chk("bp_done.cnt",   64'(err_cnt),   64'd4);
    chk("bp_done.addr",  64'(err_addr),  64'h44);
    cyc();
    chk("bp_after.pulse", 64'(err_pulse), 64'd0);

    // Saturation and clear.
    err_cnt_clr = 1'b1;
    cyc();
    err_cnt_clr = 1'b0;
    chk("clr_pre.cnt", 64'(err_cnt), 64'd0);
    for (int i = 0; i < 17; i++) do_write(32'h100 + 32'(i), 1'b0);
    chk("sat.cnt",  64'(err_cnt),  64'd15);
    chk("sat.addr", 64'(err_addr), 64'h110);
    err_cnt_clr = 1'b1;
    cyc();
    err_cnt_clr = 1'b0;
    chk("clr_alone.cnt", 64'(err_cnt), 64'd0);
    do_write(32'h200, 1'b0);
    chk("one.cnt", 64'(err_cnt), 64'd1);
    do_write(32'h204, 1'b1);
    chk("clr_b.cnt", 64'(err_cnt), 64'd1);

    // Reset while in GOT_AW: transaction dropped.
    awaddr = 32'h55; awvalid = 1'b1; wvalid = 1'b0;
    cyc();
    chk_ch("gotaw", 0, 1, 0);
    awvalid = 1'b0; aresetn = 1'b0;
    cyc();
    aresetn = 1'b1;
    chk_ch("gotaw_rst", 0, 0, 0);
    chk("gotaw_rst.cnt", 64'(err_cnt), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("gotaw_idle%0d.bvalid", i), 64'(bvalid), 64'd0);
      chk($sformatf("gotaw_idle%0d.awready", i), 64'(awready), 64'd1);
    end
    awaddr = 32'hDEAD_0000; awvalid = 1'b1; wvalid = 1'b1;
    cyc();
    chk_ch("post_rst_wr", 0, 0, 1);
    awvalid = 1'b0; wvalid = 1'b0;
    cyc();
    chk("post_rst_wr.pulse", 64'(err_pulse), 64'd1);
    chk("post_rst_wr.cnt",   64'(err_cnt),   64'd1);
    chk("post_rst_wr.addr",  64'(err_addr),  64'hDEAD_0000);

    // Back-to-back: valids held until four transactions are accepted.
    acc = 0; bhs = 0; bready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      awvalid = (acc < 4); wvalid = (acc < 4); awaddr = 32'h300 + 32'(acc);
      if (awvalid && awready && wready) acc++;
      if (bvalid) bhs++;
      cyc();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("b2b.accepted", 64'(acc), 64'd4);
    chk("b2b.bhs",      64'(bhs), 64'd4);
    chk("b2b.cnt",      64'(err_cnt),  64'd5);
    chk("b2b.addr",     64'(err_addr), 64'h303);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
